uart_transmitter: RTL and testbench

- Serialises one byte per handshake onto a UART line: 8N1 frames, LSB first, at BAUD_RATE derived from CLK_FREQ.
- Companion to the UART receiver; this block is the host-to-PC or loopback path of the JPEG decoder, e.g. for returning decoded pixel bytes.
- Upstream logic presents bytes with valid/ready; the block owns the tx pin.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_timer.sv | 20 ++
 rtl/uart_transmitter.sv | 85 ++++++++
 tb/tb_uart_transmitter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and baud-timer sizing helpers (UART_TX_PARITY_EN adds PARITY)
package uart_pkg;
`ifdef UART_TX_PARITY_EN
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif
  function automatic int timer_limit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
  function automatic int timer_reg_length(input int limit);
    return limit > 1 ? $clog2(limit) : 1;
  endfunction
endpackage

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: bit-period counter, tick marks the last cycle of each bit
// Ports: clk, rst (async active-low), clear (hold at 0), tick (timer == TIMER_LIMIT-1)
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int TIMER_LIMIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int W = timer_reg_length(TIMER_LIMIT);
  localparam logic [W-1:0] LAST = W'(TIMER_LIMIT - 1);
  logic [W-1:0] timer;
  assign tick = timer == LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) timer <= '0;
    else timer <= (clear || tick) ? '0 : timer + W'(1);
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: valid/ready byte in, 8N1 UART frame out, LSB first
// Ports: clk; rst async active-low; data[7:0]/valid in; ready out (IDLE only);
//        tx serial line (idle high); busy (frame in progress). All outputs registered.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);
  localparam int TIMER_LIMIT = timer_limit(CLK_FREQ, BAUD_RATE);
  state_t state;
  logic [7:0] shift;
  logic [2:0] bit_counter;
  logic tick;
  logic last_bit;
  uart_baud_timer #(.TIMER_LIMIT(TIMER_LIMIT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE),
    .tick(tick)
  );
`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic parity;
  always_ff @(posedge clk or negedge rst)
    if (!rst) parity <= 1'b0;
    else if (valid && ready) parity <= ^data;
  assign last_bit = parity;
`else
  localparam state_t AFTER_DATA = STOP;
  assign last_bit = 1'b1;
`endif
  // tx is loaded one edge ahead of each bit so the pin comes straight from a flop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      ready       <= 1'b1;
      busy        <= 1'b0;
      bit_counter <= 3'd0;
      shift       <= 8'd0;
    end else begin
      case (state)
        IDLE: if (valid && ready) begin
          shift <= data;
          tx    <= 1'b0;
          ready <= 1'b0;
          busy  <= 1'b1;
          state <= START;
        end
        START: if (tick) begin
          tx          <= shift[0];
          bit_counter <= 3'd0;
          state       <= DATA;
        end
        DATA: if (tick) begin
          shift       <= shift >> 1;
          bit_counter <= bit_counter + 3'd1;
          tx          <= bit_counter == 3'd7 ? last_bit : shift[1];
          state       <= bit_counter == 3'd7 ? AFTER_DATA : DATA;
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          tx    <= 1'b1;
          state <= STOP;
        end
`endif
        STOP: if (tick) begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized frame-level model check plus default-rate literal checks
module tb_uart_transmitter;
  localparam int L  = 16;
  localparam int LD = 868;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  logic clk = 0, rst = 0;
  logic [7:0] data = 0, data0 = 0;
  logic valid = 0, valid0 = 0;
  logic tx, ready, busy, tx0, ready0, busy0;
  int vec = 0, errs = 0, wn = 0;
  always #5 clk = ~clk;
  uart_transmitter #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready), .tx(tx), .busy(busy)
  );
  uart_transmitter dut0 (
    .clk(clk), .rst(rst), .data(data0), .valid(valid0), .ready(ready0), .tx(tx0), .busy(busy0)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask
  // expected line level for bit slot i of a frame carrying b
  function automatic logic fbit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction
  // model: a frame is FL*L cycles long starting the cycle after an accept
  logic act = 0;
  int t = 0;
  logic [7:0] mb = 0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      act <= 0;
      t   <= 0;
    end else if (!act) begin
      if (valid) begin
        act <= 1;
        t   <= 0;
        mb  <= data;
      end
    end else if (t == FL*L-1) act <= 0;
    else t <= t + 1;
  always @(negedge clk)
    chk("fast tx/ready/busy", {29'd0, tx, ready, busy}, act ? {29'd0, fbit(mb, t/L), 2'b01} : 32'd6);
  // loopback receiver sampling mid-bit
  logic rx_on = 0;
  logic [7:0] rb;
  logic [7:0] rxq[$];
  initial forever begin
    @(negedge clk);
    if (rx_on && tx === 1'b0) begin
      repeat (L/2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (L) @(negedge clk);
        rb[i] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (L) @(negedge clk);
      chk("rx parity", {31'd0, tx}, {31'd0, ^rb});
`endif
      repeat (L) @(negedge clk);
      chk("rx stop", {31'd0, tx}, 32'd1);
      rxq.push_back(rb);
    end
  end
  task automatic send(input logic [7:0] b, input bit hold);
    wn = 0;
    data = b;
    valid = 1;
    while (!ready && wn < 4*FL*L) begin
      @(negedge clk);
      wn++;
    end
    chk("ready wait", {31'd0, ready}, 32'd1);
    @(negedge clk);
    if (!hold) valid = 0;
  endtask
  task automatic wait_idle;
    int n = 0;
    valid = 0;
    while ((act || !ready) && n < 2*FL*L) begin
      @(negedge clk);
      n++;
    end
    chk("idle wait", {31'd0, act || !ready}, 32'd0);
    repeat (2) @(negedge clk);
  endtask
  logic [10:0] pat;
  initial begin
    #5_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
  initial begin
`ifdef UART_TX_PARITY_EN
    pat = 11'b11000001110;
    data0 = 8'h07;
`else
    pat = 11'b01010101010;
    data0 = 8'h55;
`endif
    repeat (3) @(negedge clk);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset tx0", {31'd0, tx0}, 32'd1);
    chk("reset ready0", {31'd0, ready0}, 32'd1);
    rst = 1;
    repeat (2) @(negedge clk);
    valid0 = 1;
    @(negedge clk);
    valid0 = 0;
    for (int k = 0; k <= FL*LD; k++) begin
      if (k == 0 || k == LD-1 || k == LD || k % LD == LD/2) chk("default tx", {31'd0, tx0}, {31'd0, pat[k/LD]});
      if (k == FL*LD-1) chk("default ready early", {31'd0, ready0}, 32'd0);
      if (k == FL*LD) begin
        chk("default ready", {31'd0, ready0}, 32'd1);
        chk("default busy", {31'd0, busy0}, 32'd0);
      end
      if (k < FL*LD) @(negedge clk);
    end
    send(8'h55, 0);
    wait_idle;
    send(8'hA5, 1);
    send(8'h3C, 0);
    chk("back-to-back ready gap", wn, FL*L);
    wait_idle;
    send(8'h00, 0);
    repeat (3*L) @(negedge clk);
    data = 8'hFF;
    valid = 1;
    @(negedge clk);
    valid = 0;
    wait_idle;
    send(8'h0F, 0);
    repeat (5*L + L/2) @(negedge clk);
    #1 rst = 0;
    #1;
    chk("async reset tx", {31'd0, tx}, 32'd1);
    chk("async reset ready", {31'd0, ready}, 32'd1);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    send(8'h81, 0);
    wait_idle;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), 1'($urandom));
    end
    wait_idle;
    rxq.delete();
    rx_on = 1;
    for (int b = 0; b < 256; b++) send(8'(b), 1);
    wait_idle;
    rx_on = 0;
    chk("loopback count", rxq.size(), 256);
    for (int i = 0; i < rxq.size(); i++) chk("loopback byte", {24'd0, rxq[i]}, i);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
